// File: rtl/debounce_pkg.sv
// Shared constants for the debounce_sync block: FSM state encodings and default parameters.
package debounce_pkg;

  localparam int unsigned SYNC_STAGES_DEF   = 2;
  localparam int unsigned STABLE_CYCLES_DEF = 1000;
  localparam int unsigned CNT_W_DEF         = 16;

  localparam logic [1:0] StIdleLo  = 2'd0;
  localparam logic [1:0] StCheckHi = 2'd1;
  localparam logic [1:0] StIdleHi  = 2'd2;
  localparam logic [1:0] StCheckLo = 2'd3;

  function automatic logic is_check(input logic [1:0] st);
    return (st == StCheckHi) || (st == StCheckLo);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous level; q is the last stage.
module sync_chain
  import debounce_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes and debounces a raw level; optional rise/fall pulses when
// DEBOUNCE_SYNC_PULSE_EN is defined, otherwise rise and fall are tied low.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

  logic             w_s;
  logic [1:0]       r_state;
  logic [1:0]       w_state_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  logic             r_out;
  logic             w_out_d;
  logic             w_cnt_done;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync_chain (
    .clk(clk),
    .rst(rst),
    .d  (in),
    .q  (w_s)
  );

  assign w_cnt_done = (r_cnt == CntLast);

  // Counter restarts at 1 on entry to a CHECK state so the accepting edge is the
  // STABLE_CYCLES-th consecutive synchronized sample of the new level.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_out_d   = r_out;
    case (r_state)
      StIdleLo: begin
        if (w_s) begin
          w_state_d = StCheckHi;
          w_cnt_d   = CNT_W'(1);
        end else begin
          w_cnt_d = '0;
        end
      end
      StCheckHi: begin
        if (!w_s) begin
          w_state_d = StIdleLo;
          w_cnt_d   = '0;
        end else if (w_cnt_done) begin
          w_state_d = StIdleHi;
          w_cnt_d   = '0;
          w_out_d   = 1'b1;
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      StIdleHi: begin
        if (!w_s) begin
          w_state_d = StCheckLo;
          w_cnt_d   = CNT_W'(1);
        end else begin
          w_cnt_d = '0;
        end
      end
      StCheckLo: begin
        if (w_s) begin
          w_state_d = StIdleHi;
          w_cnt_d   = '0;
        end else if (w_cnt_done) begin
          w_state_d = StIdleLo;
          w_cnt_d   = '0;
          w_out_d   = 1'b0;
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_d = StIdleLo;
        w_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdleLo;
      r_cnt   <= '0;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_out   <= w_out_d;
    end
  end

  assign out  = r_out;
  assign busy = is_check(r_state);

`ifdef DEBOUNCE_SYNC_PULSE_EN
  logic w_rise_d;
  logic w_fall_d;
  logic r_rise;
  logic r_fall;

  assign w_rise_d = (r_state == StCheckHi) && w_s && w_cnt_done;
  assign w_fall_d = (r_state == StCheckLo) && !w_s && w_cnt_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_rise_d;
      r_fall <= w_fall_d;
    end
  end

  assign rise = r_rise;
  assign fall = r_fall;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Directed and randomized checks of debounce_sync against a run-length reference model.
module tb_debounce_sync;

  localparam int unsigned SYNC_STAGES   = 2;
  localparam int unsigned STABLE_CYCLES = 4;
  localparam int unsigned CNT_W         = 16;
  localparam int          LATENCY       = 6;

`ifdef DEBOUNCE_SYNC_PULSE_EN
  localparam bit PulseEn = 1'b1;
`else
  localparam bit PulseEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic in;
  logic out;
  logic rise;
  logic fall;
  logic busy;

  int checks = 0;
  int errors = 0;
  int rise_seen = 0;
  int fall_seen = 0;

  // Reference model: input delayed by SYNC_STAGES samples, out flips once the
  // opposite level has been seen STABLE_CYCLES times in a row.
  logic mq[$];
  logic m_out;
  logic m_rise;
  logic m_fall;
  int   m_run;

  always #5 clk = ~clk;

  debounce_sync #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (out),
    .rise(rise),
    .fall(fall),
    .busy(busy)
  );

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < int'(SYNC_STAGES); i++) mq.push_back(1'b0);
    m_out  = 1'b0;
    m_run  = 0;
    m_rise = 1'b0;
    m_fall = 1'b0;
  endtask

  task automatic model_edge(input logic sampled);
    logic s;
    s = mq.pop_front();
    mq.push_back(sampled);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (s != m_out) begin
      m_run++;
      if (m_run == int'(STABLE_CYCLES)) begin
        m_out  = s;
        m_run  = 0;
        m_rise = s;
        m_fall = !s;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_bit({tag, ".out"},  out,  m_out);
    check_bit({tag, ".busy"}, busy, m_run > 0);
    check_bit({tag, ".rise"}, rise, m_rise & PulseEn);
    check_bit({tag, ".fall"}, fall, m_fall & PulseEn);
  endtask

  // One rising edge; the model sees the level of in that was present at the edge.
  task automatic step(input string tag);
    logic smp;
    smp = in;
    @(posedge clk);
    if (!rst) model_edge(smp);
    else      model_reset();
    #1;
    if (rise === 1'b1) rise_seen++;
    if (fall === 1'b1) fall_seen++;
    check_all(tag);
  endtask

  // Counts edges until out reaches target; an expired budget reports -1.
  task automatic edges_until(input logic target, input string tag, output int edges);
    edges = -1;
    for (int i = 1; i <= 20; i++) begin
      step(tag);
      if (out === target) begin
        edges = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    logic lvl;

    rst = 1'b0;
    in  = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #1;
    check_all("reset_async");
    step("reset_hold");
    step("reset_hold");
    rst = 1'b0;
    step("idle");

    // Clean 0->1 step
    rise_seen = 0;
    in = 1'b1;
    edges_until(1'b1, "clean_rise", n);
    check_int("clean_rise_latency", n, LATENCY);
    step("clean_rise_after");
    check_int("clean_rise_pulses", rise_seen, PulseEn ? 1 : 0);

    // Fall path
    fall_seen = 0;
    in = 1'b0;
    edges_until(1'b0, "fall_path", n);
    check_int("fall_latency", n, LATENCY);
    step("fall_after");
    check_int("fall_pulses", fall_seen, PulseEn ? 1 : 0);

    // Glitch shorter than STABLE_CYCLES
    rise_seen = 0;
    in = 1'b1;
    repeat (3) step("glitch_hi");
    in = 1'b0;
    repeat (8) step("glitch_lo");
    check_bit("glitch_out", out, 1'b0);
    check_bit("glitch_busy", busy, 1'b0);
    check_int("glitch_pulses", rise_seen, 0);

    // Bounce 1,0,1,0 then held 1
    rise_seen = 0;
    in = 1'b1; step("bounce");
    in = 1'b0; step("bounce");
    in = 1'b1; step("bounce");
    in = 1'b0; step("bounce");
    in = 1'b1;
    edges_until(1'b1, "bounce_hold", n);
    check_int("bounce_latency", n, LATENCY);
    repeat (3) step("bounce_after");
    check_int("bounce_pulses", rise_seen, PulseEn ? 1 : 0);

    // Reset while qualifying a rise
    in = 1'b0;
    repeat (8) step("pre_rst_mid");
    in = 1'b1;
    repeat (3) step("rst_mid_qual");
    check_bit("rst_mid_busy_before", busy, 1'b1);
    rise_seen = 0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_mid_async");
    step("rst_mid_hold");
    check_int("rst_mid_no_pulse", rise_seen, 0);
    #2 rst = 1'b0;
    edges_until(1'b1, "rst_release", n);
    check_int("rst_release_latency", n, LATENCY);

    // Random hold lengths with occasional asynchronous resets
    for (int k = 0; k < 300; k++) begin
      lvl = 1'($urandom_range(0, 1));
      n   = int'($urandom_range(1, 7));
      in  = lvl;
      for (int j = 0; j < n; j++) step("random");
      if ($urandom_range(0, 39) == 0) begin
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("random_rst");
        step("random_rst_hold");
        rst = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
